// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit of vec, with an empty flag.
// cnt reads 0 when vec has no bits set.
module lzc #(
  parameter int unsigned Width = 4,
  localparam int unsigned CntWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    vec,
  output logic [CntWidth-1:0] cnt,
  output logic                empty
);

  always_comb begin
    cnt = '0;
    // NOTE: combinational logic uses blocking '=' with a default first, so no latch is inferred.
    // Scanning from the top bit down leaves the lowest set bit as the final assignment.
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (vec[i]) cnt = CntWidth'(i);
    end
    empty = ~|vec;
  end

endmodule

// File: rtl/rr_req_scheduler.sv
// Round-robin arbiter sharing one valid/ready port among NumReq requesters.
// The selection is held while the downstream port stalls; priority rotates per transfer.
module rr_req_scheduler #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NumReq-1:0]                 req_i,
  output logic [NumReq-1:0]                 gnt_o,
  input  logic [NumReq-1:0][DataWidth-1:0]  data_i,
  output logic                              req_o,
  input  logic                              gnt_i,
  output logic [DataWidth-1:0]              data_o,
  output logic [IdxWidth-1:0]               idx_o
);

  typedef logic [IdxWidth-1:0] idx_t;

  localparam idx_t LastIdx = idx_t'(NumReq - 1);

  idx_t              rr_q;
  logic              lock_q;
  idx_t              lock_idx_q;

  logic [NumReq-1:0] prio_mask;
  logic [NumReq-1:0] masked_req;
  idx_t              masked_idx;
  idx_t              unmasked_idx;
  logic              masked_empty;
  logic              unmasked_empty;
  idx_t              sel_idx;
  idx_t              next_rr;
  logic              xfer;
  logic              stall;

  // Requesters at or above the pointer get first pick; the rest wrap around.
  always_comb begin
    prio_mask = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      prio_mask[i] = (i >= int'(rr_q));
    end
    masked_req = req_i & prio_mask;
  end

  lzc #(.Width(NumReq)) u_lzc_masked (
    .vec   (masked_req),
    .cnt   (masked_idx),
    .empty (masked_empty)
  );

  lzc #(.Width(NumReq)) u_lzc_unmasked (
    .vec   (req_i),
    .cnt   (unmasked_idx),
    .empty (unmasked_empty)
  );

  always_comb begin
    if (lock_q) begin
      sel_idx = lock_idx_q;
      req_o   = req_i[lock_idx_q];
    end else begin
      sel_idx = masked_empty ? unmasked_idx : masked_idx;
      req_o   = ~unmasked_empty;
    end
    idx_o  = sel_idx;
    data_o = data_i[sel_idx];
    gnt_o  = '0;
    gnt_o[sel_idx] = gnt_i & req_o;
  end

  assign xfer    = req_o & gnt_i;
  assign stall   = req_o & ~gnt_i;
  assign next_rr = (sel_idx == LastIdx) ? '0 : sel_idx + idx_t'(1);

  // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      rr_q   <= '0;
      lock_q <= 1'b0;
    end else if (xfer) begin
      rr_q   <= next_rr;
      lock_q <= 1'b0;
    end else if (stall) begin
      lock_q     <= 1'b1;
      lock_idx_q <= sel_idx;
    end
  end

  // A locked requester must keep asserting until its transfer completes.
  lock_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_i[lock_idx_q]);

endmodule

// File: doc/rr_req_scheduler.md
# rr_req_scheduler

- Round-robin arbiter sharing one downstream valid/ready port among `NumReq` requesters.
- Priority rotates after every accepted transfer.
- The selection is locked while the downstream port stalls, so the selected data is stable until the transfer is accepted.
- Sits in front of shared resources (memory port, FPU, bus master); the priority search uses trailing-zero counting.

## Interface
- `NumReq`, default 4: number of requesters; any value ≥ 1, need not be a power of two.
- `DataWidth`, default 32: payload width per requester.
- `IdxWidth`, default `NumReq > 1 ? $clog2(NumReq) : 1`: derived; do not override.
- `clk_i` input, 1: clock; single clock domain.
- `rst_ni` input, 1: asynchronous, active-low reset.
- `flush_i` input, 1: synchronous; resets priority pointer and lock.
- `req_i` input, `NumReq`: per-requester valid.
- `gnt_o` output, `NumReq`: per-requester ready, one-hot or zero.
- `data_i` input, `NumReq` × `DataWidth`: per-requester payload.
- `req_o` output, 1: downstream valid.
- `gnt_i` input, 1: downstream ready.
- `data_o` output, `DataWidth`: payload of the selected requester.
- `idx_o` output, `IdxWidth`: index of the selected requester.

## Operation
- **State:**
  - `rr_q`: priority pointer, `IdxWidth` bits, range 0..`NumReq`-1.
  - `lock_q`: 1 bit.
  - `lock_idx_q`: `IdxWidth` bits.
- **Search when `lock_q`=0:**
  - `masked = req_i & {bits at index ≥ rr_q}`.
  - If `masked` ≠ 0: selected index = lowest set bit of `masked`.
  - Else: selected index = lowest set bit of `req_i`.
- **Search when `lock_q`=1:** selected index = `lock_idx_q`.
- **Outputs:**
  - `req_o` = `|req_i` when unlocked; `req_i[lock_idx_q]` when locked.
  - `data_o` = `data_i[idx]`; `idx_o` = idx.
  - `gnt_o[idx]` = `gnt_i & req_o`; all other bits 0.
- **Handshake:** transfer occurs on a cycle with `req_o` & `gnt_i`.
  - On transfer: `rr_q` <= idx+1, or 0 when idx = `NumReq`-1 (wrap); `lock_q` <= 0.
- **Stall:** on a cycle with `req_o` & !`gnt_i`: `lock_q` <= 1 and `lock_idx_q` <= idx.
  - A higher-priority request arriving while locked does not change the selection.
- **Requester rule:** a requester must hold `req_i` and `data_i` stable until granted.
  - Simulation-only assertion: `lock_q` implies `req_i[lock_idx_q]`.
  - Synthesis behaviour if violated: `req_o` drops; lock is held until a transfer or flush.
- **Flush:** `flush_i`=1 → `rr_q` <= 0, `lock_q` <= 0. Flush wins over a simultaneous transfer or stall update.
  - Combinational outputs in a flush cycle are still computed from the current state; a handshake in that cycle is a real transfer.
- **No requests:** `req_o`=0, `gnt_o`=0, `idx_o`=0, `data_o` = `data_i[0]`; state unchanged.
- **`NumReq`=1:** `rr_q` stays 0; arbiter degenerates to pass-through with lock.

## Timing
- Zero-cycle latency: `req_i`/`data_i`/`gnt_i` → outputs combinationally; no register on the data path.
- **State updates:** on the rising `clk_i` edge following the handshake or stall cycle.
- **Reset (`rst_ni`=0, immediate, asynchronous):**
  - `rr_q`=0, `lock_q`=0, `lock_idx_q`=0.
  - Outputs then follow the unlocked search from pointer 0.
  - Reset mid-stall drops the lock; the stalled transfer is re-arbitrated after release.
- **Fairness:** with all requesters asserting continuously, each is granted exactly once per `NumReq` transfers.
- No combinational path from `gnt_i` to `req_o` or `idx_o`.

## Structure
- No shared package. `idx_t` is a local typedef; constants are derived from parameters.
- **Sub-module:** `lzc` in trailing-zero mode, instantiated twice (masked and unmasked request vectors).
  - Its empty flag selects between the masked and unmasked results.
- Pointer, lock and assertion logic live in this module.

## Test plan
- **Reset:** `rst_ni`=0 with `req_i`=4'b1111 → `idx_o`=0, `req_o`=1, state cleared.
- **Rotation:** `req_i`=4'b1111, `gnt_i`=1 for 8 cycles → `idx_o` sequence 0,1,2,3,0,1,2,3; `gnt_o` one-hot matching.
- **Lock:**
  - Stimulus: `req_i`=4'b0100, `gnt_i`=0 for 3 cycles, `req_i[0]` raised at cycle 2.
  - Response: `idx_o` stays 2 throughout; after `gnt_i`=1 transfers idx 2, the next selection is idx 0 via wrap (`rr_q`=3, `masked`=0).
- **Skip:** `rr_q`=1, `req_i`=4'b1001 → `idx_o`=3; after transfer `rr_q`=0, then `idx_o`=0.
- **Flush over transfer:** `flush_i`=1 together with transfer of idx 2 → `rr_q`=0 next cycle (not 3), `lock_q`=0.
- **`NumReq`=3 wrap:** `req_i`=3'b111 continuous → `idx_o` 0,1,2,0; `rr_q` never reaches 3.
